// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART register block with TX/RX byte FIFOs, sticky error flags and a level irq.
// Loads return one cycle after read_enable; a full FIFO drops the incoming byte and sets a sticky flag.
module uart_mmio_fifo #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    TX_DEPTH     = 16,
   parameter int                    RX_DEPTH     = 16,
   parameter int                    RX_IRQ_LEVEL = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   input  logic                  read_enable,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  irq,
   input  logic [7:0]            rx_data,
   input  logic                  rx_data_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_data_valid,
   input  logic                  tx_busy
);
   localparam int TCW = $clog2(TX_DEPTH + 1);
   localparam int RCW = $clog2(RX_DEPTH + 1);
   localparam int TPW = $clog2(TX_DEPTH);
   localparam int RPW = $clog2(RX_DEPTH);
   localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
   localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
   localparam logic [RCW-1:0] RX_LVL      = RCW'(RX_IRQ_LEVEL);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_ARM    = 2'd2;
   localparam logic [1:0] S_WAIT   = 2'd3;

   logic [7:0]            tx_mem_q [TX_DEPTH];
   logic [7:0]            rx_mem_q [RX_DEPTH];
   logic [TPW-1:0]        tx_wp_q, tx_rp_q;
   logic [RPW-1:0]        rx_wp_q, rx_rp_q;
   logic [TCW-1:0]        tx_cnt_q;
   logic [RCW-1:0]        rx_cnt_q;
   logic [1:0]            ctrl_q;
   logic                  rx_ovr_q, tx_ovf_q;
   logic [1:0]            state_q, state_d;
   logic [7:0]            tx_data_q;
   logic                  irq_q, irq_d;
   logic [DATA_WIDTH-1:0] read_data_q, rd_mux;

   logic sel_status, sel_data, sel_ctrl, sel_level;
   logic wr_status, wr_ctrl, wr_data, rd_data;
   logic tx_empty, tx_full, rx_empty, rx_full;
   logic rx_clr, tx_clr, rx_pop, rx_push, rx_drop, tx_push, tx_drop, tx_pop;
   logic [6:0] status;
   logic unused_wdata;

   assign sel_status = (addr == BASE_ADDR);
   assign sel_data   = (addr == BASE_ADDR + ADDR_WIDTH'(4));
   assign sel_ctrl   = (addr == BASE_ADDR + ADDR_WIDTH'(8));
   assign sel_level  = (addr == BASE_ADDR + ADDR_WIDTH'(12));

   assign wr_status = write_enable & sel_status;
   assign wr_ctrl   = write_enable & sel_ctrl;
   assign wr_data   = write_enable & sel_data;
   assign rd_data   = read_enable & sel_data;

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == RX_FULL_CNT);

   // Clears win over same-cycle pushes; an RX pop frees the slot a full-FIFO push needs.
   assign rx_clr  = wr_ctrl & write_data[2];
   assign tx_clr  = wr_ctrl & write_data[3];
   assign rx_pop  = rd_data & ~rx_empty;
   assign rx_push = rx_data_valid & ~rx_clr & (~rx_full | rx_pop);
   assign rx_drop = rx_data_valid & ~rx_clr & rx_full & ~rx_pop;
   assign tx_push = wr_data & ~tx_clr & ~tx_full;
   assign tx_drop = wr_data & ~tx_clr & tx_full;
   assign tx_pop  = (state_q == S_LAUNCH) & ~tx_empty;

   assign status = {tx_ovf_q, rx_ovr_q, (state_q != S_IDLE) | tx_busy,
                    tx_full, tx_empty, rx_full, ~rx_empty};
   assign unused_wdata = ^write_data[DATA_WIDTH-1:8];

   always_comb begin
      rd_mux = '0;
      if (sel_status)                 rd_mux = DATA_WIDTH'(status);
      else if (sel_data && !rx_empty) rd_mux = DATA_WIDTH'(rx_mem_q[rx_rp_q]);
      else if (sel_ctrl)              rd_mux = DATA_WIDTH'(ctrl_q);
      else if (sel_level)             rd_mux = DATA_WIDTH'({8'(tx_cnt_q), 8'(rx_cnt_q)});
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!tx_empty && !tx_busy && !tx_clr) state_d = S_LAUNCH;
         S_LAUNCH: state_d = S_ARM;
         S_ARM:    state_d = S_WAIT;
         S_WAIT:   if (!tx_busy) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign irq_d = (ctrl_q[0] & (rx_cnt_q >= RX_LVL)) |
                  (ctrl_q[1] & tx_empty & (state_q == S_IDLE));

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= write_data[7:0];
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wp_q     <= '0;
         tx_rp_q     <= '0;
         tx_cnt_q    <= '0;
         rx_wp_q     <= '0;
         rx_rp_q     <= '0;
         rx_cnt_q    <= '0;
         ctrl_q      <= '0;
         rx_ovr_q    <= 1'b0;
         tx_ovf_q    <= 1'b0;
         state_q     <= S_IDLE;
         tx_data_q   <= '0;
         irq_q       <= 1'b0;
         read_data_q <= '0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         if (read_enable) read_data_q <= rd_mux;
         if (wr_ctrl) ctrl_q <= write_data[1:0];
         if (state_q == S_IDLE && state_d == S_LAUNCH) tx_data_q <= tx_mem_q[tx_rp_q];
         rx_ovr_q <= rx_drop | (rx_ovr_q & ~(wr_status & write_data[5]));
         tx_ovf_q <= tx_drop | (tx_ovf_q & ~(wr_status & write_data[6]));

         if (tx_clr) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
         end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + TPW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TPW'(1);
            case ({tx_push, tx_pop})
               2'b10:   tx_cnt_q <= tx_cnt_q + TCW'(1);
               2'b01:   tx_cnt_q <= tx_cnt_q - TCW'(1);
               default: tx_cnt_q <= tx_cnt_q;
            endcase
         end

         if (rx_clr) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
         end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RPW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RPW'(1);
            case ({rx_push, rx_pop})
               2'b10:   rx_cnt_q <= rx_cnt_q + RCW'(1);
               2'b01:   rx_cnt_q <= rx_cnt_q - RCW'(1);
               default: rx_cnt_q <= rx_cnt_q;
            endcase
         end
      end
   end

   assign read_data     = read_data_q;
   assign irq           = irq_q;
   assign tx_data       = tx_data_q;
   assign tx_data_valid = (state_q == S_LAUNCH);
endmodule
